// File: rtl/port_pkg.sv
// Shared constants and width helpers for the host byte port and the
// convolution input stage.
//   BYTE_W          : width of one host-port byte
//   MAX_WIDTH_BYTES : widest assembled word supported downstream
//   MAX_FIFO_DEPTH  : deepest word buffer supported downstream
//   clog2()         : ceiling log2, constant-foldable
//   idx_width()     : width of a counter over n positions, never zero
package port_pkg;

  localparam int BYTE_W          = 8;
  localparam int MAX_WIDTH_BYTES = 16;
  localparam int MAX_FIFO_DEPTH  = 64;
  localparam int MAX_WORD_W      = MAX_WIDTH_BYTES * BYTE_W;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // A 1-position counter still needs one bit of storage.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/port_word_fifo.sv
// First-word-fall-through FIFO holding completed words.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full and not popping)
//   push_data  : word to store
//   pop        : consume head (ignored when empty)
//   head       : oldest stored word, zero when empty
//   count      : number of words held
//   full/empty : occupancy flags
module port_word_fifo
  import port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic [clog2(DEPTH):0] count,
  output logic               full,
  output logic               empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  assign do_pop_s  = pop && !empty_s;
  // A full FIFO may still take a word when the head leaves in the same cycle.
  assign do_push_s = push && (!full_s || do_pop_s);

  assign head  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

  // Storage array write port; contents need no reset since count gates the head.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy registers; pointers wrap as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/port_word_assembler.sv
// Packs the host byte stream into WIDTH_BYTES-wide words (first byte in the
// most significant lane), buffers them and hands them on with valid/ready.
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_byte/in_valid/in_ready : byte input handshake
//   flush         : discard the partial word, buffered words are kept
//   out_word/out_valid/out_ready : word output handshake (FWFT head)
//   fill_level    : words held in the buffer
//   partial_drop  : one-cycle pulse when a partial word is discarded
// Optional: define PORT_ASM_TIMEOUT_EN to discard a partial word after
// TIMEOUT_CYCLES idle cycles; otherwise a partial word waits indefinitely.
module port_word_assembler
  import port_pkg::*;
#(
  parameter int WIDTH_BYTES    = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BYTE_W-1:0]             in_byte,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [WIDTH_BYTES*BYTE_W-1:0] out_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [clog2(FIFO_DEPTH):0]    fill_level,
  output logic                          partial_drop
);

  localparam int WORD_W = WIDTH_BYTES * BYTE_W;
  localparam int IDX_W  = idx_width(WIDTH_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic [WORD_W-1:0] shreg_r;
  logic [WORD_W-1:0] shreg_nxt_s;
  logic              run_r;
  logic              drop_r;
  logic              drop_nxt_s;
  logic [WORD_W-1:0] word_s;
  logic              accept_s;
  logic              last_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              in_ready_s;
  logic              timeout_s;
  int                lane_shift_s;

  assign last_s   = (idx_r == LAST_IDX);
  assign pop_s    = out_ready && !empty_s;
  // Only a word-completing byte can be refused, and only if no slot frees up.
  assign in_ready_s = run_r && (!last_s || !full_s || (out_ready && !empty_s));
  assign accept_s = in_valid && in_ready_s;
  assign push_s   = accept_s && last_s && !flush;

  // Place the incoming byte into its lane of the word under construction.
  always_comb begin
    lane_shift_s = (WIDTH_BYTES - 1 - int'(idx_r)) * BYTE_W;
    word_s       = shreg_r | (WORD_W'(in_byte) << lane_shift_s);
  end

`ifdef PORT_ASM_TIMEOUT_EN
  localparam int IDLE_W = clog2(TIMEOUT_CYCLES) + 1;
  logic [IDLE_W-1:0] idle_r;

  assign timeout_s = (idx_r != IDX_ZERO) && !accept_s &&
                     (idle_r == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while a partial word waits without new bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_r <= {IDLE_W{1'b0}};
    end else if (flush || accept_s || timeout_s || (idx_r == IDX_ZERO)) begin
      idle_r <= {IDLE_W{1'b0}};
    end else begin
      idle_r <= idle_r + IDLE_W'(1'b1);
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next index / shift register / drop pulse; flush wins over a coinciding byte.
  always_comb begin
    idx_nxt_s   = idx_r;
    shreg_nxt_s = shreg_r;
    drop_nxt_s  = 1'b0;
    if (flush) begin
      idx_nxt_s   = IDX_ZERO;
      shreg_nxt_s = {WORD_W{1'b0}};
      drop_nxt_s  = (idx_r != IDX_ZERO);
    end else if (accept_s) begin
      if (last_s) begin
        idx_nxt_s   = IDX_ZERO;
        shreg_nxt_s = {WORD_W{1'b0}};
      end else begin
        idx_nxt_s   = idx_r + IDX_W'(1'b1);
        shreg_nxt_s = word_s;
      end
    end else if (timeout_s) begin
      idx_nxt_s   = IDX_ZERO;
      shreg_nxt_s = {WORD_W{1'b0}};
      drop_nxt_s  = 1'b1;
    end else begin
      idx_nxt_s   = idx_r;
      shreg_nxt_s = shreg_r;
    end
  end

  // Packing state plus the run flag that holds in_ready low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= IDX_ZERO;
      shreg_r <= {WORD_W{1'b0}};
      drop_r  <= 1'b0;
      run_r   <= 1'b0;
    end else begin
      idx_r   <= idx_nxt_s;
      shreg_r <= shreg_nxt_s;
      drop_r  <= drop_nxt_s;
      run_r   <= 1'b1;
    end
  end

  port_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (word_s),
    .pop       (pop_s),
    .head      (out_word),
    .count     (fill_level),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign in_ready     = in_ready_s;
  assign out_valid    = !empty_s;
  assign partial_drop = drop_r;

endmodule
